// File: rtl/perf_pkg.sv
// Shared types and default constants for the performance monitor slice.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } perf_state_e;

  localparam logic [31:0] PERF_PRINT_PC = 32'h0000_0014;
  localparam logic [31:0] PERF_END_PC   = 32'h0000_001c;
  localparam logic [31:0] PERF_TIMEOUT  = 32'd1000000;

endpackage

// File: rtl/perf_char_fifo.sv
// Console character FIFO; wrap-bit pointers distinguish full from empty, head reads as zero when empty.
module perf_char_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              last_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic              do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign last_o  = ((wptr_q - rptr_q) == (AW+1)'(1));

  // A pop frees the slot a simultaneous push into a full FIFO needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wptr_d = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
  assign rptr_d = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;

  assign data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!reset_ni || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/perf_monitor.sv
// Test-run performance monitor: RUN-window cycle/event counters with saturation,
// end-of-test detection, timeout, and a buffered console character stream.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned NUM_EVT    = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] PRINT_PC   = PERF_PRINT_PC,
  parameter logic [31:0] END_PC     = PERF_END_PC,
  parameter logic [31:0] TIMEOUT    = PERF_TIMEOUT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic [31:0]              i_pc_debug,
  input  logic                     i_insn_vld,
  input  logic [NUM_EVT-1:0]       i_evt,
  input  logic [7:0]               i_char,
  input  logic                     i_char_rdy,
  output logic                     o_char_vld,
  output logic [7:0]               o_char,
  output logic                     o_char_ovf,
  output logic [CNT_W-1:0]         o_cycle_cnt,
  output logic [NUM_EVT*CNT_W-1:0] o_evt_cnt,
  output logic [NUM_EVT:0]         o_sat,
  output logic [1:0]               o_state,
  output logic                     o_done,
  output logic                     o_timeout
);

  localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;

  perf_state_e      state_q;
  logic             timeout_q, ovf_q;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             cycle_sat_q, cycle_sat_d, cycle_hit;
  logic [CMP_W-1:0] cycle_ext, timeout_m1;
  logic             run_cyc, timeout_hit, end_seen;
  logic             push, pop, fifo_full, fifo_empty, fifo_last, soft_rst;

  // Returns {increment attempted at all-ones, next value}.
  function automatic logic [CNT_W:0] sat_step(input logic [CNT_W-1:0] v, input logic en);
    if (!en)  return {1'b0, v};
    if (&v)   return {1'b1, v};
    return {1'b0, v + CNT_W'(1)};
  endfunction

  // The IDLE cycle that sees the first valid instruction already belongs to the run.
  assign run_cyc     = (state_q == ST_RUN) || ((state_q == ST_IDLE) && i_insn_vld);
  assign cycle_ext   = CMP_W'(cycle_q);
  assign timeout_m1  = CMP_W'(TIMEOUT) - CMP_W'(1);
  assign timeout_hit = (TIMEOUT != 32'd0) && (cycle_ext == timeout_m1);
  assign end_seen    = !i_insn_vld && (i_pc_debug == END_PC);
  assign push        = run_cyc && i_insn_vld && (i_pc_debug == PRINT_PC);
  assign pop         = o_char_vld && i_char_rdy;
  assign soft_rst    = !i_reset || i_clear;

  always_ff @(posedge i_clk) begin
    if (soft_rst) begin
      state_q   <= ST_IDLE;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (i_insn_vld) begin
            state_q   <= timeout_hit ? ST_DONE : ST_RUN;
            timeout_q <= timeout_hit;
          end
        end
        ST_RUN: begin
          if (timeout_hit) begin
            state_q   <= ST_DONE;
            timeout_q <= 1'b1;
          end else if (end_seen) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty || (pop && fifo_last)) state_q <= ST_DONE;
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  assign {cycle_hit, cycle_d} = sat_step(cycle_q, run_cyc);
  assign cycle_sat_d          = cycle_sat_q | cycle_hit;

  always_ff @(posedge i_clk) begin
    if (soft_rst) begin
      cycle_q     <= '0;
      cycle_sat_q <= 1'b0;
    end else begin
      cycle_q     <= cycle_d;
      cycle_sat_q <= cycle_sat_d;
    end
  end

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d, hit;

    assign {hit, cnt_d} = sat_step(cnt_q, run_cyc && i_evt[k]);
    assign sat_d        = sat_q | hit;

    always_ff @(posedge i_clk) begin
      if (soft_rst) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        sat_q <= sat_d;
      end
    end

    assign o_evt_cnt[k*CNT_W +: CNT_W] = cnt_q;
    assign o_sat[k]                    = sat_q;
  end

  perf_char_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk_i    (i_clk),
    .reset_ni (i_reset),
    .flush_i  (i_clear),
    .push_i   (push),
    .pop_i    (pop),
    .data_i   (i_char),
    .data_o   (o_char),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .last_o   (fifo_last)
  );

  assign o_char_vld     = !fifo_empty;
  assign o_char_ovf     = ovf_q;
  assign o_cycle_cnt    = cycle_q;
  assign o_sat[NUM_EVT] = cycle_sat_q;
  assign o_state        = state_q;
  assign o_done         = (state_q == ST_DONE);
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench: instance A (CNT_W=4, FIFO_DEPTH=4, no timeout), instance B (TIMEOUT=8).
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n, clr, vld, rdy;
  logic [31:0] pc;
  logic [2:0]  evt;
  logic [7:0]  ch;

  logic        a_char_vld, a_ovf, a_done, a_timeout;
  logic [7:0]  a_char;
  logic [3:0]  a_cycle, a_sat;
  logic [11:0] a_evt;
  logic [1:0]  a_state;

  logic        b_char_vld, b_ovf, b_done, b_timeout;
  logic [7:0]  b_char;
  logic [31:0] b_cycle;
  logic [3:0]  b_sat;
  logic [95:0] b_evt;
  logic [1:0]  b_state;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  perf_monitor #(.CNT_W(4), .NUM_EVT(3), .FIFO_DEPTH(4), .TIMEOUT(32'd0)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clr), .i_pc_debug(pc), .i_insn_vld(vld),
    .i_evt(evt), .i_char(ch), .i_char_rdy(rdy), .o_char_vld(a_char_vld), .o_char(a_char),
    .o_char_ovf(a_ovf), .o_cycle_cnt(a_cycle), .o_evt_cnt(a_evt), .o_sat(a_sat),
    .o_state(a_state), .o_done(a_done), .o_timeout(a_timeout)
  );

  perf_monitor #(.TIMEOUT(32'd8)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clr), .i_pc_debug(pc), .i_insn_vld(vld),
    .i_evt(evt), .i_char(ch), .i_char_rdy(rdy), .o_char_vld(b_char_vld), .o_char(b_char),
    .o_char_ovf(b_ovf), .o_cycle_cnt(b_cycle), .o_evt_cnt(b_evt), .o_sat(b_sat),
    .o_state(b_state), .o_done(b_done), .o_timeout(b_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; vld = 1'b0; pc = 32'h0; evt = 3'b000; ch = 8'h00; rdy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_state"}, 64'(a_state), 64'd0);
    chk({tag, "_cycle"}, 64'(a_cycle), 64'd0);
    chk({tag, "_evt"},   64'(a_evt),   64'd0);
    chk({tag, "_sat"},   64'(a_sat),   64'd0);
    chk({tag, "_ovf"},   64'(a_ovf),   64'd0);
    chk({tag, "_cvld"},  64'(a_char_vld), 64'd0);
    chk({tag, "_char"},  64'(a_char),  64'd0);
    chk({tag, "_done"},  64'(a_done),  64'd0);
    chk({tag, "_tmo"},   64'(a_timeout), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset values
    do_reset();
    chk_a_zero("rst");
    chk("rst_b_cycle", 64'(b_cycle), 64'd0);

    // 10 RUN cycles, evt=011 on 4 of them, then END_PC
    for (int i = 0; i < 10; i++) begin
      vld = 1'b1;
      pc  = 32'h100 + 32'(i * 4);
      evt = (i == 1 || i == 3 || i == 5 || i == 7) ? 3'b011 : 3'b000;
      step();
      if (i == 0) begin
        chk("run_first_state", 64'(a_state), 64'd1);
        chk("run_first_cycle", 64'(a_cycle), 64'd1);
      end
    end
    vld = 1'b0; pc = 32'h1c; evt = 3'b000;
    step();
    chk("end_state", 64'(a_state), 64'd2);
    chk("end_cycle", 64'(a_cycle), 64'd11);
    chk("end_evt0",  64'(a_evt[3:0]),  64'd4);
    chk("end_evt1",  64'(a_evt[7:4]),  64'd4);
    chk("end_evt2",  64'(a_evt[11:8]), 64'd0);
    chk("end_done",  64'(a_done), 64'd0);
    pc = 32'h0; evt = 3'b111;
    step();
    chk("drain_done",   64'(a_done), 64'd1);
    chk("drain_cycle",  64'(a_cycle), 64'd11);
    chk("drain_evt2",   64'(a_evt[11:8]), 64'd0);
    vld = 1'b1; evt = 3'b001;
    step();
    chk("done_hold_state", 64'(a_state), 64'd3);
    chk("done_hold_evt0",  64'(a_evt[3:0]), 64'd4);

    // "HI" through the console FIFO, held in DRAIN until the consumer is ready
    do_reset();
    vld = 1'b1; pc = 32'h100;
    step();
    pc = 32'h14; ch = 8'h48;
    step();
    chk("hi_vld_after_H", 64'(a_char_vld), 64'd1);
    chk("hi_head_H",      64'(a_char), 64'h48);
    ch = 8'h49;
    step();
    pc = 32'h18; ch = 8'h00;
    step();
    vld = 1'b0; pc = 32'h1c;
    step();
    pc = 32'h0;
    step();
    step();
    chk("hi_stall_state", 64'(a_state), 64'd2);
    chk("hi_stall_head",  64'(a_char), 64'h48);
    rdy = 1'b1;
    step();
    chk("hi_pop_I_head",  64'(a_char), 64'h49);
    chk("hi_pop_state",   64'(a_state), 64'd2);
    step();
    chk("hi_empty",       64'(a_char_vld), 64'd0);
    chk("hi_done_state",  64'(a_state), 64'd3);
    rdy = 1'b0;

    // Overflow: 5 pushes into depth 4 with no pop
    do_reset();
    vld = 1'b1; pc = 32'h100;
    step();
    pc = 32'h14;
    for (int i = 0; i < 5; i++) begin
      ch = 8'h61 + 8'(i);
      step();
    end
    chk("ovf_set", 64'(a_ovf), 64'd1);
    vld = 1'b0; pc = 32'h100; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_rd_vld",  64'(a_char_vld), 64'd1);
      chk("ovf_rd_char", 64'(a_char), 64'(8'h61 + 8'(i)));
      step();
    end
    chk("ovf_rd_empty", 64'(a_char_vld), 64'd0);
    chk("ovf_sticky",   64'(a_ovf), 64'd1);
    rdy = 1'b0;

    // Same, but the 5th push coincides with a pop
    do_reset();
    vld = 1'b1; pc = 32'h100;
    step();
    pc = 32'h14;
    for (int i = 0; i < 4; i++) begin
      ch = 8'h61 + 8'(i);
      step();
    end
    ch = 8'h65; rdy = 1'b1;
    step();
    chk("nov_ovf",  64'(a_ovf), 64'd0);
    vld = 1'b0; pc = 32'h100;
    for (int i = 1; i < 5; i++) begin
      chk("nov_rd_char", 64'(a_char), 64'(8'h61 + 8'(i)));
      step();
    end
    chk("nov_rd_empty", 64'(a_char_vld), 64'd0);
    rdy = 1'b0;

    // 4-bit counter saturation over 20 RUN cycles
    do_reset();
    vld = 1'b1; pc = 32'h100; evt = 3'b100;
    for (int i = 0; i < 15; i++) step();
    chk("sat15_cycle", 64'(a_cycle), 64'd15);
    chk("sat15_flags", 64'(a_sat), 64'h0);
    step();
    chk("sat16_flags", 64'(a_sat), 64'hc);
    for (int i = 0; i < 4; i++) step();
    chk("sat20_cycle", 64'(a_cycle), 64'd15);
    chk("sat20_evt2",  64'(a_evt[11:8]), 64'd15);
    chk("sat20_evt0",  64'(a_evt[3:0]), 64'd0);
    chk("sat20_flags", 64'(a_sat), 64'hc);

    // TIMEOUT=8 on B; A has the limit disabled
    do_reset();
    vld = 1'b1; pc = 32'h100; evt = 3'b000;
    for (int i = 0; i < 7; i++) step();
    chk("tmo7_state", 64'(b_state), 64'd1);
    chk("tmo7_flag",  64'(b_timeout), 64'd0);
    step();
    chk("tmo8_state", 64'(b_state), 64'd3);
    chk("tmo8_flag",  64'(b_timeout), 64'd1);
    chk("tmo8_cycle", 64'(b_cycle), 64'd8);
    chk("tmo8_done",  64'(b_done), 64'd1);
    chk("tmo_off_a",  64'(a_state), 64'd1);
    step();
    chk("tmo9_cycle", 64'(b_cycle), 64'd8);

    // Clear in DONE
    vld = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_b_state", 64'(b_state), 64'd0);
    chk("clr_b_cycle", 64'(b_cycle), 64'd0);
    chk("clr_b_tmo",   64'(b_timeout), 64'd0);
    chk("clr_b_done",  64'(b_done), 64'd0);
    chk_a_zero("clr_a");

    // Reset during RUN with buffered characters and counts
    vld = 1'b1; pc = 32'h14; evt = 3'b001; ch = 8'h78;
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_cvld", 64'(a_char_vld), 64'd1);
    chk("pre_rst_evt0", 64'(a_evt[3:0]), 64'd3);
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_a_zero("rst_run");

    // Simultaneous clear and reset after an overflow
    vld = 1'b1; pc = 32'h14; evt = 3'b011;
    for (int i = 0; i < 5; i++) step();
    chk("pre_both_ovf", 64'(a_ovf), 64'd1);
    rst_n = 1'b0; clr = 1'b1;
    step();
    rst_n = 1'b1; clr = 1'b0; vld = 1'b0; evt = 3'b000;
    chk_a_zero("both");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
